// File: rtl/mat_loader_if.sv
// mat_loader_if: FP32 element stream in, vmem write port out
interface mat_loader_if #(parameter int ADDR_W = 32);
  logic in_valid;
  logic in_ready;
  logic [31:0] in_data;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wd;
  modport master(output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wd);
  modport slave(input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wd);
endinterface

// File: rtl/mat_loader.sv
// mat_loader: writes a streamed FP32 matrix into vmem as rows, cols, row-major elements; MAT_LOADER_NAN_CHECK_EN adds NaN counting
module mat_loader #(
  parameter int DIM_W = 16,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic [ADDR_W-1:0] base_addr,
  input logic [DIM_W-1:0] rows,
  input logic [DIM_W-1:0] cols,
  mat_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic err
`ifdef MAT_LOADER_NAN_CHECK_EN
  ,
  output logic nan_seen,
  output logic [2*DIM_W-1:0] nan_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, HDR_R, HDR_C, DATA, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, mem_addr_q, mem_addr_d;
  logic [DIM_W-1:0] cols_q, cols_d;
  logic [2*DIM_W-1:0] rem_q, rem_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic in_ready_q, in_ready_d, mem_we_q, mem_we_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic accept, dims_ok;
`ifdef MAT_LOADER_NAN_CHECK_EN
  logic nan_seen_q, nan_seen_d;
  logic [2*DIM_W-1:0] nan_cnt_q, nan_cnt_d;
  logic is_nan;
  assign is_nan = bus.in_data[30:23] == 8'hFF && bus.in_data[22:0] != '0;
`endif
  assign accept = bus.in_valid & in_ready_q;
  assign dims_ok = rows != '0 && cols != '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cols_d = cols_q;
    rem_d = rem_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d = mem_wd_q;
    mem_we_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
`ifdef MAT_LOADER_NAN_CHECK_EN
    nan_seen_d = nan_seen_q;
    nan_cnt_d = nan_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        err_d = start & ~dims_ok;
        if (start && dims_ok) begin
          state_d = HDR_R;
          ptr_d = base_addr;
          cols_d = cols;
          rem_d = (2*DIM_W)'(rows) * (2*DIM_W)'(cols);
          mem_we_d = 1'b1;
          mem_addr_d = base_addr;
          mem_wd_d = 32'(rows);
          busy_d = 1'b1;
`ifdef MAT_LOADER_NAN_CHECK_EN
          nan_seen_d = 1'b0;
          nan_cnt_d = '0;
`endif
        end
      end
      HDR_R: begin
        state_d = HDR_C;
        mem_we_d = 1'b1;
        mem_addr_d = ptr_q + ADDR_W'(4);
        mem_wd_d = 32'(cols_q);
        ptr_d = ptr_q + ADDR_W'(8);
      end
      HDR_C: state_d = DATA;
      DATA: begin
        if (accept) begin
          mem_we_d = 1'b1;
          mem_addr_d = ptr_q;
          mem_wd_d = bus.in_data;
          ptr_d = ptr_q + ADDR_W'(4);
          rem_d = rem_q - (2*DIM_W)'(1);
`ifdef MAT_LOADER_NAN_CHECK_EN
          nan_seen_d = nan_seen_q | is_nan;
          nan_cnt_d = is_nan ? nan_cnt_q + (2*DIM_W)'(1) : nan_cnt_q;
`endif
        end else if (rem_q == '0) begin
          state_d = FIN;
          done_d = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == DATA && rem_d != '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cols_q <= '0;
      rem_q <= '0;
      mem_addr_q <= '0;
      mem_wd_q <= '0;
      mem_we_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef MAT_LOADER_NAN_CHECK_EN
      nan_seen_q <= 1'b0;
      nan_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cols_q <= cols_d;
      rem_q <= rem_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q <= mem_wd_d;
      mem_we_q <= mem_we_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef MAT_LOADER_NAN_CHECK_EN
      nan_seen_q <= nan_seen_d;
      nan_cnt_q <= nan_cnt_d;
`endif
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd = mem_wd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
`ifdef MAT_LOADER_NAN_CHECK_EN
  assign nan_seen = nan_seen_q;
  assign nan_cnt = nan_cnt_q;
`endif
endmodule
